// File: rtl/darkriscv_dmem_responder_if.sv
// Data-port bundle between the darkriscv core (master) and its data memory responder (slave).
interface darkriscv_dmem_responder_if;
    logic        das;
    logic        drd;
    logic        dwr;
    logic [2:0]  dlen;
    logic [31:0] daddr;
    logic [31:0] datao;
    logic [31:0] datai;
    logic        hlt;
    logic        derr;

    modport master (
        output das, drd, dwr, dlen, daddr, datao,
        input  datai, hlt, derr
    );

    modport slave (
        input  das, drd, dwr, dlen, daddr, datao,
        output datai, hlt, derr
    );
endinterface

// File: rtl/darkriscv_dmem_responder.sv
// Word-RAM data memory for the darkriscv core: fixed wait states via HLT,
// byte-lane writes, full-word reads and a one-cycle error pulse on bad requests.
module darkriscv_dmem_responder #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    darkriscv_dmem_responder_if.slave   bus
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [31:0]   DEPTH_W  = 32'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            do_access;
    logic            hlt;
    logic            req;

    logic            below_base;
    logic [29:0]     word_off;
    logic [1:0]      byte_off;
    logic [AW-1:0]   idx;
    logic            in_range;
    logic            bad_len;
    logic            misaligned;
    logic            err;
    logic [3:0]      be;

    logic [31:0]     mem [DEPTH];

    assign req = bus.das & (bus.drd | bus.dwr);

    // 33-bit subtraction: the borrow flags addresses below the RAM window
    assign {below_base, word_off, byte_off} = {1'b0, bus.daddr} - {1'b0, BASE_ADDR};
    assign idx        = word_off[AW-1:0];
    assign in_range   = !below_base && ({2'b00, word_off} < DEPTH_W);
    assign bad_len    = !(bus.dlen inside {3'd1, 3'd2, 3'd4});
    assign misaligned = ((bus.dlen == 3'd2) && byte_off[0]) ||
                        ((bus.dlen == 3'd4) && (byte_off != 2'b00));
    assign err        = (bus.drd & bus.dwr) | !in_range | bad_len | misaligned;

    always_comb begin
        be = 4'b1111;
        case (bus.dlen)
            3'd1:    be = 4'b0001 << byte_off;
            3'd2:    be = 4'b0011 << byte_off;
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        do_access  = 1'b0;
        hlt        = 1'b0;
        case (state)
            S_IDLE: begin
                hlt = req;
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        do_access  = 1'b1;
                        state_next = S_RESP;
                    end else begin
                        cnt_next   = CNT_INIT;
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                hlt = 1'b1;
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    do_access  = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // the stall must release the core as soon as reset is asserted
        if (!rst_n) begin
            hlt = 1'b0;
        end
    end

    assign bus.hlt = hlt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.datai <= 32'h0;
            bus.derr  <= 1'b0;
        end else begin
            bus.derr <= do_access & err;
            if (do_access && bus.drd) begin
                bus.datai <= err ? 32'h0 : mem[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_access && bus.dwr && !err) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[idx][8*k +: 8] <= bus.datao[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_darkriscv_dmem_responder.sv
// Randomized self-checking bench for darkriscv_dmem_responder (WAIT_CYCLES=2 and 0 builds).
module tb_darkriscv_dmem_responder;

    localparam int WAITS = 2;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    darkriscv_dmem_responder_if bus ();
    darkriscv_dmem_responder_if bus0 ();

    darkriscv_dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(WAITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    darkriscv_dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    int compared = 0;
    int mismatched = 0;

    logic [31:0] model_mem  [DEPTH];
    logic [31:0] model0_mem [DEPTH];
    logic [31:0] model_datai = 32'h0;
    logic [31:0] model0_datai = 32'h0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A request is legal only for a single-access-size naturally aligned word inside the RAM
    function automatic bit model_err(input bit rd, input bit wr, input int len, input logic [31:0] addr);
        if (rd && wr) return 1'b1;
        if (addr >= 32'(4 * DEPTH)) return 1'b1;
        if (!(len == 1 || len == 2 || len == 4)) return 1'b1;
        return (int'(addr[3:0]) % len) != 0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input int len, input logic [31:0] addr);
        logic [31:0] r;
        int first;
        r = old;
        first = int'(addr[1:0]);
        for (int k = first; k < first + len; k++) r[8*k +: 8] = wdata[8*k +: 8];
        return r;
    endfunction

    task automatic finishAccess(input bit rd, input bit wr, input int len,
                                input logic [31:0] addr, input logic [31:0] wdata);
        int stalls;
        bit err;
        int idx;
        stalls = 0;
        err = model_err(rd, wr, len, addr);
        idx = int'(addr >> 2);
        #1;
        while (bus.hlt === 1'b1 && stalls < 20) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        checkOutput("stall_cycles", 32'(stalls), 32'(WAITS + 1));
        checkOutput("resp_derr", {31'b0, bus.derr}, {31'b0, err});
        if (!err && wr) model_mem[idx] = merge(model_mem[idx], wdata, len, addr);
        if (rd) begin
            if (err) model_datai = 32'h0;
            else     model_datai = model_mem[idx];
        end
        checkOutput("resp_datai", bus.datai, model_datai);
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input int len,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.das   = 1'b1;
        bus.drd   = rd;
        bus.dwr   = wr;
        bus.dlen  = 3'(len);
        bus.daddr = addr;
        bus.datao = wdata;
        finishAccess(rd, wr, len, addr, wdata);
    endtask

    task automatic idleCycles(input int n);
        @(negedge clk);
        bus.das = 1'b0;
        bus.drd = 1'b0;
        bus.dwr = 1'b0;
        #1;
        checkOutput("idle_hlt", {31'b0, bus.hlt}, 32'h0);
        checkOutput("idle_derr", {31'b0, bus.derr}, 32'h0);
        checkOutput("idle_datai_hold", bus.datai, model_datai);
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic access0(input bit rd, input bit wr, input int len,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int stalls;
        bit err;
        int idx;
        @(negedge clk);
        bus0.das   = 1'b1;
        bus0.drd   = rd;
        bus0.dwr   = wr;
        bus0.dlen  = 3'(len);
        bus0.daddr = addr;
        bus0.datao = wdata;
        stalls = 0;
        err = model_err(rd, wr, len, addr);
        idx = int'(addr >> 2);
        #1;
        while (bus0.hlt === 1'b1 && stalls < 20) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        checkOutput("w0_stall_cycles", 32'(stalls), 32'd1);
        checkOutput("w0_resp_derr", {31'b0, bus0.derr}, {31'b0, err});
        if (!err && wr) model0_mem[idx] = merge(model0_mem[idx], wdata, len, addr);
        if (rd) begin
            if (err) model0_datai = 32'h0;
            else     model0_datai = model0_mem[idx];
        end
        checkOutput("w0_resp_datai", bus0.datai, model0_datai);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        int len;
        bit rd;
        bit wr;
        logic [31:0] addr;
        logic [31:0] data;

        bus.das = 1'b0;  bus.drd = 1'b0;  bus.dwr = 1'b0;
        bus.dlen = 3'd4; bus.daddr = 32'h0; bus.datao = 32'h0;
        bus0.das = 1'b0; bus0.drd = 1'b0; bus0.dwr = 1'b0;
        bus0.dlen = 3'd4; bus0.daddr = 32'h0; bus0.datao = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("reset_hlt", {31'b0, bus.hlt}, 32'h0);
        checkOutput("reset_datai", bus.datai, 32'h0);
        checkOutput("reset_derr", {31'b0, bus.derr}, 32'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 32; k++) applyStimulus(1'b0, 1'b1, 4, 32'(k * 4), $urandom);
        idleCycles(2);

        // Directed cases on the two-wait-state build
        applyStimulus(1'b0, 1'b1, 4, 32'h10, 32'h1234_5678);
        applyStimulus(1'b1, 1'b0, 4, 32'h10, 32'h0);
        checkOutput("t1_word_read", bus.datai, 32'h1234_5678);
        applyStimulus(1'b0, 1'b1, 1, 32'h11, 32'hAAAA_AAAA);
        applyStimulus(1'b1, 1'b0, 4, 32'h10, 32'h0);
        checkOutput("t2_byte_merge", bus.datai, 32'h1234_AA78);
        applyStimulus(1'b0, 1'b1, 2, 32'h13, 32'h5555_5555);
        applyStimulus(1'b1, 1'b0, 4, 32'h10, 32'h0);
        checkOutput("t3_unchanged", bus.datai, 32'h1234_AA78);
        applyStimulus(1'b1, 1'b1, 4, 32'h10, 32'h0);
        applyStimulus(1'b1, 1'b0, 4, 32'h1000, 32'h0);
        applyStimulus(1'b0, 1'b1, 4, 32'h1000, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b0, 4, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 3, 32'h8, 32'h0);
        idleCycles(1);

        // Back-to-back read, read, write then a read to confirm the write
        applyStimulus(1'b1, 1'b0, 4, 32'h4, 32'h0);
        applyStimulus(1'b1, 1'b0, 4, 32'h8, 32'h0);
        applyStimulus(1'b0, 1'b1, 2, 32'hC, 32'hBEEF_CAFE);
        applyStimulus(1'b1, 1'b0, 4, 32'hC, 32'h0);
        idleCycles(2);

        // Zero-wait-state build
        access0(1'b0, 1'b1, 4, 32'h40, 32'hCAFE_F00D);
        access0(1'b1, 1'b0, 4, 32'h40, 32'h0);
        access0(1'b0, 1'b1, 1, 32'h43, 32'h1111_1111);
        access0(1'b1, 1'b0, 4, 32'h40, 32'h0);
        access0(1'b0, 1'b1, 2, 32'h40, 32'h2222_3333);
        access0(1'b1, 1'b0, 4, 32'h40, 32'h0);
        access0(1'b1, 1'b0, 4, 32'h2000, 32'h0);
        @(negedge clk);
        bus0.das = 1'b0;

        // Reset in the middle of a stalled write abandons it
        @(negedge clk);
        bus.das = 1'b1; bus.drd = 1'b0; bus.dwr = 1'b1;
        bus.dlen = 3'd4; bus.daddr = 32'h20; bus.datao = 32'hDEAD_BEEF;
        #1;
        checkOutput("rst_hlt_before", {31'b0, bus.hlt}, 32'h1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_hlt_drop", {31'b0, bus.hlt}, 32'h0);
        checkOutput("rst_datai", bus.datai, 32'h0);
        checkOutput("rst_derr", {31'b0, bus.derr}, 32'h0);
        model_datai = 32'h0;
        model0_datai = 32'h0;
        @(negedge clk);
        bus.das = 1'b0;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 4, 32'h20, 32'h0);

        // Reset again, released with the request still held: full latency restarts
        @(negedge clk);
        bus.das = 1'b1; bus.drd = 1'b0; bus.dwr = 1'b1;
        bus.dlen = 3'd4; bus.daddr = 32'h20; bus.datao = 32'hDEAD_BEEF;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_hlt_drop", {31'b0, bus.hlt}, 32'h0);
        model_datai = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        finishAccess(1'b0, 1'b1, 4, 32'h20, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, 4, 32'h20, 32'h0);
        checkOutput("rst2_write_done", bus.datai, 32'hDEAD_BEEF);

        // Randomized traffic, mostly legal, with a share of bad sizes, misalignment and out-of-range
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 19);
            rd = (r < 10) || (r == 19);
            wr = (r >= 10);
            r = $urandom_range(0, 9);
            len = (r < 3) ? 1 : (r < 6) ? 2 : (r < 9) ? 4 : int'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 4) != 0 && (len == 2 || len == 4)) addr = addr & ~32'(len - 1);
            r = $urandom_range(0, 9);
            if (r == 0)      addr = 32'h1000 + 32'($urandom_range(0, 255));
            else if (r == 1) addr = 32'hFFFF_FFFC;
            data = $urandom;
            applyStimulus(rd, wr, len, addr, data);
            if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 2)));
        end
        idleCycles(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
